// File: rtl/data_store_buffer.sv
// data_store_buffer: posted-write buffer between the core data port and the
// SRAM-like-to-AXI bridge. Stores are acked one cycle after acceptance and
// drained in order; loads pass through once ordering is safe.
// Optional feature macro: DSB_READ_BYPASS_EN (cached loads may bypass pending
// stores to other words).
module data_store_buffer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    cpu_req,
    input  logic                    cpu_wr,
    input  logic                    cpu_uncached,
    input  logic [1:0]              cpu_size,
    input  logic [31:0]             cpu_addr,
    input  logic [31:0]             cpu_wdata,
    output logic [31:0]             cpu_rdata,
    output logic                    cpu_addr_ok,
    output logic                    cpu_data_ok,
    output logic                    mem_req,
    output logic                    mem_wr,
    output logic                    mem_uncached,
    output logic [1:0]              mem_size,
    output logic [31:0]             mem_addr,
    output logic [31:0]             mem_wdata,
    input  logic [31:0]             mem_rdata,
    input  logic                    mem_addr_ok,
    input  logic                    mem_data_ok,
    output logic [$clog2(DEPTH):0]  buf_count,
    output logic                    buf_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {IDLE, WR_ADDR, WR_DATA, RD_DATA} state_e;

    state_e          state_q;
    logic [AW-1:0]   head_q, tail_q;
    logic [CW-1:0]   count_q, count_d;
    logic            wr_ack_q;

    logic [31:0]     addr_q  [DEPTH];
    logic [31:0]     wdata_q [DEPTH];
    logic [1:0]      size_q  [DEPTH];
    logic            unc_q   [DEPTH];

    logic            empty, full, push, pop, ld_ok, ld_elig;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign push      = cpu_req & cpu_wr & ~full & (state_q != RD_DATA);
    assign pop       = (state_q == WR_DATA) & mem_data_ok;
    assign buf_count = count_q;
    assign buf_empty = empty;

`ifdef DSB_READ_BYPASS_EN
    logic hit;

    // Word-granular match of the load address against every valid entry
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [AW-1:0] off;
            off = AW'(i) - head_q;
            if ((CW'(off) < count_q) && (addr_q[i][31:2] == cpu_addr[31:2]))
                hit = 1'b1;
        end
    end

    assign ld_ok = empty | (~cpu_uncached & ~hit);
`else
    assign ld_ok = empty;
`endif

    assign ld_elig = cpu_req & ~cpu_wr & ~wr_ack_q & (state_q == IDLE) & ld_ok;

    // Occupancy update; push and pop together leave it unchanged
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = CW'(count_q + CW'(1));
            2'b01:   count_d = CW'(count_q - CW'(1));
            default: count_d = count_q;
        endcase
    end

    // Downstream request mux and core-side handshakes
    always_comb begin
        cpu_addr_ok  = push;
        cpu_data_ok  = wr_ack_q;
        cpu_rdata    = '0;
        mem_req      = 1'b0;
        mem_wr       = 1'b0;
        mem_uncached = 1'b0;
        mem_size     = '0;
        mem_addr     = '0;
        mem_wdata    = '0;
        case (state_q)
            IDLE: begin
                if (ld_elig) begin
                    mem_req      = 1'b1;
                    mem_uncached = cpu_uncached;
                    mem_size     = cpu_size;
                    mem_addr     = cpu_addr;
                    mem_wdata    = cpu_wdata;
                    cpu_addr_ok  = mem_addr_ok;
                end else if (!empty) begin
                    mem_req      = 1'b1;
                    mem_wr       = 1'b1;
                    mem_uncached = unc_q[head_q];
                    mem_size     = size_q[head_q];
                    mem_addr     = addr_q[head_q];
                    mem_wdata    = wdata_q[head_q];
                end
            end
            WR_ADDR: begin
                mem_req      = 1'b1;
                mem_wr       = 1'b1;
                mem_uncached = unc_q[head_q];
                mem_size     = size_q[head_q];
                mem_addr     = addr_q[head_q];
                mem_wdata    = wdata_q[head_q];
            end
            RD_DATA: begin
                cpu_data_ok = mem_data_ok;
                cpu_rdata   = mem_rdata;
            end
            default: ;
        endcase
    end

    // Control state: FSM, pointers, count and store ack
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= IDLE;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            wr_ack_q <= 1'b0;
        end else begin
            wr_ack_q <= push;
            count_q  <= count_d;
            if (push) tail_q <= AW'(tail_q + AW'(1));
            if (pop)  head_q <= AW'(head_q + AW'(1));
            case (state_q)
                IDLE: begin
                    if (ld_elig) begin
                        if (mem_addr_ok) state_q <= RD_DATA;
                    end else if (!empty) begin
                        state_q <= mem_addr_ok ? WR_DATA : WR_ADDR;
                    end
                end
                WR_ADDR: if (mem_addr_ok) state_q <= WR_DATA;
                WR_DATA: if (mem_data_ok) state_q <= IDLE;
                RD_DATA: if (mem_data_ok) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Entry storage written at the tail on store accept
    always_ff @(posedge aclk) begin
        if (push) begin
            addr_q[tail_q]  <= cpu_addr;
            wdata_q[tail_q] <= cpu_wdata;
            size_q[tail_q]  <= cpu_size;
            unc_q[tail_q]   <= cpu_uncached;
        end
    end

endmodule

// File: tb/tb_data_store_buffer.sv
// Directed bench for data_store_buffer (DEPTH=4): vector tables for the
// single-store and load-ordering cases, hand sequences for backpressure,
// push/pop overlap, mid-transaction reset and (when built with
// DSB_READ_BYPASS_EN) the load bypass.
module tb_data_store_buffer;

    logic        aclk, aresetn;
    logic        cpu_req, cpu_wr, cpu_uncached;
    logic [1:0]  cpu_size;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_addr_ok, cpu_data_ok;
    logic        mem_req, mem_wr, mem_uncached;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [2:0]  buf_count;
    logic        buf_empty;

    int n_cmp = 0;
    int n_err = 0;

    data_store_buffer #(.DEPTH(4)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_uncached(cpu_uncached),
        .cpu_size(cpu_size), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_addr_ok(cpu_addr_ok), .cpu_data_ok(cpu_data_ok),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_uncached(mem_uncached),
        .mem_size(mem_size), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
        .buf_count(buf_count), .buf_empty(buf_empty)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    typedef struct {
        logic        req, wr, unc;
        logic [31:0] addr, wdata;
        logic        maok, mdok;
        logic [31:0] mrd;
        logic        e_aok, e_dok, e_mreq, e_mwr;
        logic [31:0] e_maddr, e_mwd, e_rdata;
        logic [3:0]  e_cnt;
    } vec_t;

    function automatic vec_t mk(input logic req, wr, unc, input logic [31:0] addr, wdata,
                                input logic maok, mdok, input logic [31:0] mrd,
                                input logic aok, dok, mreq, mwr,
                                input logic [31:0] maddr, mwd, rdata, input logic [3:0] cnt);
        vec_t v;
        v.req = req; v.wr = wr; v.unc = unc; v.addr = addr; v.wdata = wdata;
        v.maok = maok; v.mdok = mdok; v.mrd = mrd;
        v.e_aok = aok; v.e_dok = dok; v.e_mreq = mreq; v.e_mwr = mwr;
        v.e_maddr = maddr; v.e_mwd = mwd; v.e_rdata = rdata; v.e_cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge aclk);
        #1;
    endtask

    task automatic cpu_drive(input logic req, wr, unc, input logic [31:0] addr, wdata);
        cpu_req = req; cpu_wr = wr; cpu_uncached = unc;
        cpu_size = 2'd2; cpu_addr = addr; cpu_wdata = wdata;
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        cpu_drive(v.req, v.wr, v.unc, v.addr, v.wdata);
        mem_addr_ok = v.maok; mem_data_ok = v.mdok; mem_rdata = v.mrd;
        @(negedge aclk);
        chk({tag, ".addr_ok"}, 32'(cpu_addr_ok), 32'(v.e_aok));
        chk({tag, ".data_ok"}, 32'(cpu_data_ok), 32'(v.e_dok));
        chk({tag, ".mem_req"}, 32'(mem_req), 32'(v.e_mreq));
        chk({tag, ".rdata"}, cpu_rdata, v.e_rdata);
        chk({tag, ".count"}, 32'(buf_count), 32'(v.e_cnt));
        chk({tag, ".empty"}, 32'(buf_empty), 32'(v.e_cnt == 4'd0));
        if (v.e_mreq) begin
            chk({tag, ".mem_wr"}, 32'(mem_wr), 32'(v.e_mwr));
            chk({tag, ".mem_addr"}, mem_addr, v.e_maddr);
            chk({tag, ".mem_size"}, 32'(mem_size), 32'd2);
            if (v.e_mwr) chk({tag, ".mem_wdata"}, mem_wdata, v.e_mwd);
        end
        cyc();
    endtask

    // Wait for the next store on the memory side, check it, then complete it
    task automatic drain_one(input string tag, input logic [31:0] ea, input logic [31:0] ed);
        bit seen = 1'b0;
        mem_addr_ok = 1'b1; mem_data_ok = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge aclk);
            if (mem_req) begin
                seen = 1'b1;
                chk({tag, ".mem_wr"}, 32'(mem_wr), 32'd1);
                chk({tag, ".mem_addr"}, mem_addr, ea);
                chk({tag, ".mem_wdata"}, mem_wdata, ed);
            end
            cyc();
        end
        chk({tag, ".seen"}, 32'(seen), 32'd1);
        mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
        cyc();
        mem_data_ok = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ".addr_ok"}, 32'(cpu_addr_ok), 32'd0);
        chk({tag, ".data_ok"}, 32'(cpu_data_ok), 32'd0);
        chk({tag, ".mem_req"}, 32'(mem_req), 32'd0);
        chk({tag, ".mem_addr"}, mem_addr, 32'd0);
        chk({tag, ".rdata"}, cpu_rdata, 32'd0);
        chk({tag, ".count"}, 32'(buf_count), 32'd0);
        chk({tag, ".empty"}, 32'(buf_empty), 32'd1);
    endtask

`ifdef DSB_READ_BYPASS_EN
    // Leave the FSM in IDLE holding entries 0x200 and 0x204
    task automatic setup_two();
        mem_addr_ok = 1'b1; mem_data_ok = 1'b0;
        cpu_drive(1, 1, 0, 32'h1FC, 32'h10); cyc();
        cpu_drive(1, 1, 0, 32'h200, 32'h11); cyc();
        mem_addr_ok = 1'b0;
        cpu_drive(1, 1, 0, 32'h204, 32'h12); cyc();
        cpu_drive(0, 0, 0, 32'h0, 32'h0);
        mem_data_ok = 1'b1; cyc();
        mem_data_ok = 1'b0;
    endtask

    task automatic finish_load(input string tag, input logic [31:0] rd);
        cyc();
        cpu_drive(0, 0, 0, 32'h0, 32'h0);
        mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = rd;
        @(negedge aclk);
        chk({tag, ".rd_ok"}, 32'(cpu_data_ok), 32'd1);
        chk({tag, ".rdata"}, cpu_rdata, rd);
        cyc();
        mem_data_ok = 1'b0;
    endtask
`endif

    vec_t s1[$];
    vec_t s3[$];

    initial begin
        // Single word store drained with immediate addr_ok
        s1.push_back(mk(1,1,0,32'h1FAF_8000,32'h1234_5678, 1,0,32'hCAFE_F00D, 1,0,0,0, 0,0,0, 0));
        s1.push_back(mk(0,0,0,32'h0,32'h0,               1,0,32'hCAFE_F00D, 0,1,1,1, 32'h1FAF_8000,32'h1234_5678,0, 1));
        s1.push_back(mk(0,0,0,32'h0,32'h0,               0,1,32'hCAFE_F00D, 0,0,0,0, 0,0,0, 1));
        s1.push_back(mk(0,0,0,32'h0,32'h0,               0,0,32'hCAFE_F00D, 0,0,0,0, 0,0,0, 0));
        // Two stores then a load of the first address: load waits for empty
        s3.push_back(mk(1,1,0,32'h100,32'hAAAA_0001, 1,0,32'hCAFE_F00D, 1,0,0,0, 0,0,0, 0));
        s3.push_back(mk(1,1,0,32'h104,32'hBBBB_0002, 1,0,32'hCAFE_F00D, 1,1,1,1, 32'h100,32'hAAAA_0001,0, 1));
        s3.push_back(mk(1,0,0,32'h100,32'h0,         1,1,32'hCAFE_F00D, 0,1,0,0, 0,0,0, 2));
        s3.push_back(mk(1,0,0,32'h100,32'h0,         1,0,32'hCAFE_F00D, 0,0,1,1, 32'h104,32'hBBBB_0002,0, 1));
        s3.push_back(mk(1,0,0,32'h100,32'h0,         1,1,32'hCAFE_F00D, 0,0,0,0, 0,0,0, 1));
        s3.push_back(mk(1,0,0,32'h100,32'h0,         1,0,32'hCAFE_F00D, 1,0,1,0, 32'h100,0,0, 0));
        s3.push_back(mk(0,0,0,32'h100,32'h0,         0,1,32'hCAFE_F00D, 0,1,0,0, 0,0,32'hCAFE_F00D, 0));
        s3.push_back(mk(0,0,0,32'h0,32'h0,           0,0,32'hCAFE_F00D, 0,0,0,0, 0,0,0, 0));

        aresetn = 1'b0;
        cpu_drive(0, 0, 0, 32'h0, 32'h0);
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'hCAFE_F00D;
        #12;
        check_reset("reset");
        @(negedge aclk);
        aresetn = 1'b1;
        cyc();

        foreach (s1[i]) run_vec($sformatf("s1[%0d]", i), s1[i]);

        // Backpressure: four stores fill the buffer, the fifth waits for a pop
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cpu_drive(1, 1, 0, 32'h1000 + 32'(4 * k), 32'hA0 + 32'(k));
            @(negedge aclk);
            chk($sformatf("s2.acc%0d", k), 32'(cpu_addr_ok), 32'd1);
            cyc();
        end
        cpu_drive(1, 1, 0, 32'h1010, 32'hA4);
        @(negedge aclk);
        chk("s2.full_aok", 32'(cpu_addr_ok), 32'd0);
        chk("s2.full_cnt", 32'(buf_count), 32'd4);
        cyc();
        mem_addr_ok = 1'b1;
        @(negedge aclk);
        chk("s2.hs_aok", 32'(cpu_addr_ok), 32'd0);
        chk("s2.hs_addr", mem_addr, 32'h1000);
        cyc();
        mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
        @(negedge aclk);
        chk("s2.pop_aok", 32'(cpu_addr_ok), 32'd0);
        chk("s2.pop_mreq", 32'(mem_req), 32'd0);
        cyc();
        mem_data_ok = 1'b0;
        @(negedge aclk);
        chk("s2.fifth_aok", 32'(cpu_addr_ok), 32'd1);
        chk("s2.fifth_cnt", 32'(buf_count), 32'd3);
        chk("s2.next_head", mem_addr, 32'h1004);
        cyc();
        cpu_drive(0, 0, 0, 32'h0, 32'h0);
        @(negedge aclk);
        chk("s2.refill_cnt", 32'(buf_count), 32'd4);
        cyc();
        for (int k = 1; k < 5; k++)
            drain_one($sformatf("s2.drain%0d", k), 32'h1000 + 32'(4 * k), 32'hA0 + 32'(k));
        @(negedge aclk);
        chk("s2.empty", 32'(buf_empty), 32'd1);
        cyc();

`ifndef DSB_READ_BYPASS_EN
        foreach (s3[i]) run_vec($sformatf("s3[%0d]", i), s3[i]);
`endif

        // Push in the same cycle as the head pop, count stays at 2
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
        cpu_drive(1, 1, 0, 32'h400, 32'h40); cyc();
        cpu_drive(1, 1, 0, 32'h404, 32'h41); cyc();
        cpu_drive(0, 0, 0, 32'h0, 32'h0);
        mem_addr_ok = 1'b1;
        @(negedge aclk);
        chk("s5.cnt_before", 32'(buf_count), 32'd2);
        chk("s5.head", mem_addr, 32'h400);
        cyc();
        mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
        cpu_drive(1, 1, 0, 32'h408, 32'h42);
        @(negedge aclk);
        chk("s5.push_aok", 32'(cpu_addr_ok), 32'd1);
        cyc();
        mem_data_ok = 1'b0;
        cpu_drive(0, 0, 0, 32'h0, 32'h0);
        @(negedge aclk);
        chk("s5.cnt_after", 32'(buf_count), 32'd2);
        chk("s5.ack", 32'(cpu_data_ok), 32'd1);
        cyc();
        drain_one("s5.d0", 32'h404, 32'h41);
        drain_one("s5.d1", 32'h408, 32'h42);

        // Reset while WR_ADDR holds the head of three entries
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
        cpu_drive(1, 1, 0, 32'h500, 32'h50); cyc();
        cpu_drive(1, 1, 0, 32'h504, 32'h51); cyc();
        cpu_drive(1, 1, 0, 32'h508, 32'h52); cyc();
        cpu_drive(0, 0, 0, 32'h0, 32'h0);
        @(negedge aclk);
        chk("s6.pre_mreq", 32'(mem_req), 32'd1);
        chk("s6.pre_cnt", 32'(buf_count), 32'd3);
        #1 aresetn = 1'b0;
        #1 check_reset("s6.rst");
        @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        cyc();
        foreach (s1[i]) run_vec($sformatf("s6.s1[%0d]", i), s1[i]);

`ifdef DSB_READ_BYPASS_EN
        // Cached load to an unrelated word goes ahead of pending stores
        setup_two();
        cpu_drive(1, 0, 0, 32'h300, 32'h0);
        mem_addr_ok = 1'b1;
        @(negedge aclk);
        chk("byp.mreq", 32'(mem_req), 32'd1);
        chk("byp.mwr", 32'(mem_wr), 32'd0);
        chk("byp.maddr", mem_addr, 32'h300);
        chk("byp.aok", 32'(cpu_addr_ok), 32'd1);
        chk("byp.cnt", 32'(buf_count), 32'd2);
        finish_load("byp", 32'h3333_3333);
        // Load that hits a pending word waits for empty
        cpu_drive(1, 0, 0, 32'h204, 32'h0);
        @(negedge aclk);
        chk("hit.aok", 32'(cpu_addr_ok), 32'd0);
        chk("hit.mwr", 32'(mem_wr), 32'd1);
        chk("hit.maddr", mem_addr, 32'h200);
        cyc();
        drain_one("hit.d0", 32'h200, 32'h11);
        drain_one("hit.d1", 32'h204, 32'h12);
        mem_addr_ok = 1'b1;
        @(negedge aclk);
        chk("hit.ld_mwr", 32'(mem_wr), 32'd0);
        chk("hit.ld_addr", mem_addr, 32'h204);
        chk("hit.ld_aok", 32'(cpu_addr_ok), 32'd1);
        chk("hit.empty", 32'(buf_empty), 32'd1);
        finish_load("hit", 32'h2044_2044);
        // Uncached load never bypasses
        setup_two();
        cpu_drive(1, 0, 1, 32'h300, 32'h0);
        @(negedge aclk);
        chk("unc.aok", 32'(cpu_addr_ok), 32'd0);
        chk("unc.mwr", 32'(mem_wr), 32'd1);
        chk("unc.maddr", mem_addr, 32'h200);
        cyc();
        drain_one("unc.d0", 32'h200, 32'h11);
        drain_one("unc.d1", 32'h204, 32'h12);
        mem_addr_ok = 1'b1;
        @(negedge aclk);
        chk("unc.ld_mwr", 32'(mem_wr), 32'd0);
        chk("unc.ld_unc", 32'(mem_uncached), 32'd1);
        chk("unc.ld_aok", 32'(cpu_addr_ok), 32'd1);
        finish_load("unc", 32'h0BAD_CAFE);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/data_store_buffer.md
# data_store_buffer

Posted-write buffer between the CPU core's SRAM-like data port and the SRAM-like-to-AXI bridge. Stores are acknowledged to the core one cycle after acceptance and drained to memory in order in the background. Loads are passed through combinationally once ordering against buffered stores is guaranteed. The instruction port is not touched.

## Interface
- DEPTH, 4: number of store entries; power of two, ≥2.
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- cpu_req / cpu_wr / cpu_uncached  in  1 each  core request, write flag, uncached flag
- cpu_size  in  2  0=byte, 1=half, 2=word
- cpu_addr / cpu_wdata  in  32 each  request address / store data
- cpu_rdata  out  32  load data
- cpu_addr_ok / cpu_data_ok  out  1 each  request accepted / response valid
- mem_req / mem_wr / mem_uncached  out  1 each  downstream request fields
- mem_size  out  2;  mem_addr / mem_wdata  out  32 each
- mem_rdata  in  32;  mem_addr_ok / mem_data_ok  in  1 each
- buf_count  out  $clog2(DEPTH)+1  valid entries
- buf_empty  out  1  buf_count==0

## Operation
- Each entry holds {addr[31:0], wdata[31:0], size[1:0], uncached}. Circular FIFO with head/tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, plus a count register.
- SRAM-like rules on both sides: a requester holds all request fields until addr_ok. Responses return in acceptance order. At most one downstream transaction is outstanding.
- Store accept condition: cpu_req & cpu_wr & count<DEPTH & state≠RD_DATA. On accept, cpu_addr_ok=1 in the same cycle and the entry is written at tail. The write uses the count at the start of the cycle, so a full buffer refuses even if a pop occurs in that cycle.
- Store ack: registered wr_ack is set on accept and causes cpu_data_ok=1 in the next cycle.
- Load eligibility: cpu_req & ~cpu_wr & ~wr_ack & state==IDLE & buffer empty.
- Downstream FSM:
  - IDLE:
    - If a load is eligible, mem_* = cpu_* combinationally and cpu_addr_ok = mem_addr_ok. Go to RD_DATA on handshake.
    - Otherwise, if not empty, drive the head entry with mem_wr=1. Go to WR_DATA on mem_addr_ok, else go to WR_ADDR.
  - WR_ADDR: hold the head entry on mem_req. Go to WR_DATA on mem_addr_ok.
  - WR_DATA: mem_req=0. On mem_data_ok, pop head and go to IDLE.
  - RD_DATA: mem_req=0. cpu_data_ok = mem_data_ok and cpu_rdata = mem_rdata, both combinational. Go to IDLE on mem_data_ok.
- Simultaneous push and pop: count unchanged, both pointers advance.
- cpu_rdata is 0 whenever not in RD_DATA.

## Timing
- Reset values: all outputs 0 except buf_empty=1. FSM=IDLE, pointers and count 0, wr_ack 0.
- Store: accept at cycle N → cpu_data_ok at N+1. Earliest mem_req for that entry is N+1.
- Load: zero added latency; addr_ok and data_ok are pass-throughs.
- Reset asserted mid-transaction clears all state at once. The bridge shares aresetn, so no outstanding transaction survives reset.

## Configuration
- DSB_READ_BYPASS_EN defined:
  - In IDLE, a cached load is also eligible when the buffer is not empty, provided no valid entry has addr[31:2] equal to cpu_addr[31:2].
  - An eligible load takes priority over draining in IDLE.
  - Uncached loads still require an empty buffer.
- DSB_READ_BYPASS_EN undefined: loads wait for an empty buffer, and no compare logic is built.

## Test plan
- Store word 0x1234_5678 to 0x1FAF_8000 with mem_addr_ok=1:
  - cpu_addr_ok at cycle 0, cpu_data_ok at cycle 1.
  - mem_req with the same address, data and size=2 at cycle 1.
  - buf_count 1, then 0 after mem_data_ok.
- DEPTH=4, mem_addr_ok held 0, five back-to-back stores:
  - four accepted, buf_count=4.
  - fifth held with cpu_addr_ok=0.
  - fifth accepted the cycle after the first mem_data_ok.
- Stores to 0x100 and 0x104, then a load of 0x100 (bypass off):
  - load mem_req appears only after both stores complete, buf_empty=1.
  - cpu_rdata = mem_rdata with cpu_data_ok the same cycle.
- Bypass on, two entries pending at 0x200/0x204:
  - cached load of 0x300 is issued before the head store drains.
  - load of 0x204 waits until empty.
  - uncached load of 0x300 waits until empty.
- buf_count=2, a new store accepted in the same cycle as mem_data_ok for the head: buf_count stays 2, FIFO order preserved on drain.
- aresetn pulsed low while in WR_ADDR with 3 entries:
  - mem_req drops immediately, buf_count=0, buf_empty=1.
  - a subsequent store behaves as in the first scenario.
